// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states, shifter modes and the flag bundle.
package alu_mc_pkg;

  typedef enum logic [4:0] {
    OP_DEC  = 5'b00010,
    OP_CMP  = 5'b00101,
    OP_ADD  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_ROR  = 5'b01001,
    OP_MUL  = 5'b01010,
    OP_SUB  = 5'b01110,
    OP_AND  = 5'b01111,
    OP_XOR  = 5'b10000,
    OP_SHR  = 5'b10001,
    OP_RCR  = 5'b10010,
    OP_SHL  = 5'b10011,
    OP_RCL  = 5'b10100,
    OP_OR   = 5'b10101,
    OP_ASR  = 5'b11000,
    OP_CMPU = 5'b11011,
    OP_NOT  = 5'b11100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    SH_LSL,
    SH_LSR,
    SH_ASR,
    SH_ROL,
    SH_ROR
  } shift_e;

  typedef struct packed {
    logic c_o;
    logic zero;
    logic equal;
    logic gt;
    logic lt;
  } flags_t;

endpackage

// File: rtl/alu_mc_if.sv
// Request/result bus of the multi-cycle ALU; the controller is the master, the ALU the slave.
interface alu_mc_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             c_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             c_o;
  logic             zero;
  logic             equal;
  logic             gt;
  logic             lt;

  modport master (
    output in_valid, op, in_a, in_b, c_i, out_ready,
    input  in_ready, out_valid, out, out_hi, c_o, zero, equal, gt, lt
  );

  modport slave (
    input  in_valid, op, in_a, in_b, c_i, out_ready,
    output in_ready, out_valid, out, out_hi, c_o, zero, equal, gt, lt
  );
endinterface

// File: rtl/alu_mc_shifter.sv
// Combinational log-stage barrel shifter; left modes reuse the right-shift network on bit-reversed data.
module alu_mc_shifter
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  shift_e           mode,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amount,
  output logic [WIDTH-1:0] result,
  output logic             c_o
);

  logic             left;
  logic             rot;
  logic             arith;
  logic [WIDTH-1:0] rev_in;
  logic [WIDTH-1:0] rev_out;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] spill;
  logic [SHW-1:0]   step;
  logic             carry;

  assign left  = (mode == SH_LSL) || (mode == SH_ROL);
  assign rot   = (mode == SH_ROL) || (mode == SH_ROR);
  assign arith = (mode == SH_ASR);

  // Each stage moves by 2^k; the last bit leaving the low end is the carry.
  always_comb begin
    rev_in  = {<<{a}};
    data    = left ? rev_in : a;
    carry   = 1'b0;
    spill   = '0;
    step    = '0;
    for (int k = 0; k < SHW; k++) begin
      step = amount >> k;
      if (step[0]) begin
        spill = data >> ((1 << k) - 1);
        carry = spill[0];
        if (rot) begin
          data = (data >> (1 << k)) | (data << (WIDTH - (1 << k)));
        end else if (arith) begin
          data = $signed(data) >>> (1 << k);
        end else begin
          data = data >> (1 << k);
        end
      end
    end
    rev_out = {<<{data}};
    result  = left ? rev_out : data;
    c_o     = carry;
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish on the accept edge, MUL iterates one partial product per cycle.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic    clk,
  input  logic    reset,
  alu_mc_if.slave bus
);

  state_e             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic [WIDTH-1:0]   out_hi_q, out_hi_d;
  flags_t             flags_q, flags_d;

  shift_e             sh_mode;
  logic [WIDTH-1:0]   sh_result;
  logic               sh_c;
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [WIDTH-1:0]   alu_res;
  flags_t             alu_flags;
  logic               is_cmp;
  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  alu_mc_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .mode   (sh_mode),
    .a      (bus.in_a),
    .amount (bus.in_b[SHW-1:0]),
    .result (sh_result),
    .c_o    (sh_c)
  );

  assign bus.in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign add_ext = {1'b0, bus.in_a} + {1'b0, bus.in_b} + {{WIDTH{1'b0}}, bus.c_i};
  assign sub_ext = {1'b0, bus.in_a} - {1'b0, bus.in_b} - {{WIDTH{1'b0}}, bus.c_i};

  // High half plus multiplicand, then the whole product register slides right one bit.
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

  always_comb begin
    sh_mode = SH_LSR;
    case (bus.op)
      OP_SHL:  sh_mode = SH_LSL;
      OP_ASR:  sh_mode = SH_ASR;
      OP_ROL:  sh_mode = SH_ROL;
      OP_ROR:  sh_mode = SH_ROR;
      default: sh_mode = SH_LSR;
    endcase
  end

  always_comb begin
    alu_res   = '0;
    alu_flags = '0;
    is_cmp    = 1'b0;
    case (bus.op)
      OP_ADD:  {alu_flags.c_o, alu_res} = add_ext;
      OP_SUB:  {alu_flags.c_o, alu_res} = sub_ext;
      OP_DEC:  alu_res = bus.in_a - WIDTH'(1);
      OP_AND:  alu_res = bus.in_a & bus.in_b;
      OP_OR:   alu_res = bus.in_a | bus.in_b;
      OP_XOR:  alu_res = bus.in_a ^ bus.in_b;
      OP_NOT:  alu_res = ~bus.in_a;
      OP_SHL, OP_SHR, OP_ASR, OP_ROL, OP_ROR: begin
        alu_res       = sh_result;
        alu_flags.c_o = sh_c;
      end
      OP_RCR: begin
        alu_res       = {bus.c_i, bus.in_a[WIDTH-1:1]};
        alu_flags.c_o = bus.in_a[0];
      end
      OP_RCL: begin
        alu_res       = {bus.in_a[WIDTH-2:0], bus.c_i};
        alu_flags.c_o = bus.in_a[WIDTH-1];
      end
      OP_CMP: begin
        is_cmp       = 1'b1;
        alu_flags.gt = $signed(bus.in_a) > $signed(bus.in_b);
        alu_flags.lt = $signed(bus.in_a) < $signed(bus.in_b);
      end
      OP_CMPU: begin
        is_cmp       = 1'b1;
        alu_flags.gt = bus.in_a > bus.in_b;
        alu_flags.lt = bus.in_a < bus.in_b;
      end
      default: alu_res = '0;
    endcase
    alu_flags.equal = is_cmp && (bus.in_a == bus.in_b);
    alu_flags.zero  = is_cmp ? (bus.in_a == bus.in_b) : (alu_res == '0);
  end

  // Output registers only change on a completed operation, so stalled results stay stable.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    out_d    = out_q;
    out_hi_d = out_hi_q;
    flags_d  = flags_q;
    case (state_q)
      ST_MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d       = ST_DONE;
          out_d         = mul_next[WIDTH-1:0];
          out_hi_d      = mul_next[2*WIDTH-1:WIDTH];
          flags_d       = '0;
          flags_d.c_o   = |mul_next[2*WIDTH-1:WIDTH];
          flags_d.zero  = (mul_next[WIDTH-1:0] == '0);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = state_q;
    endcase
    if (accept) begin
      if (bus.op == OP_MUL) begin
        state_d = ST_MUL;
        cnt_d   = '0;
        mcand_d = bus.in_a;
        prod_d  = {{WIDTH{1'b0}}, bus.in_b};
      end else begin
        state_d  = ST_DONE;
        out_d    = alu_res;
        out_hi_d = '0;
        flags_d  = alu_flags;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out       = out_q;
  assign bus.out_hi    = out_hi_q;
  assign bus.c_o       = flags_q.c_o;
  assign bus.zero      = flags_q.zero;
  assign bus.equal     = flags_q.equal;
  assign bus.gt        = flags_q.gt;
  assign bus.lt        = flags_q.lt;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): directed vector table, multi-cycle corner sequences, random vs. model.
module tb_alu_mc;
  import alu_mc_pkg::*;

  localparam int W = 8;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] hi;
    logic       c_o;
    logic       zero;
    logic       equal;
    logic       gt;
    logic       lt;
  } res_t;

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    res_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  vec_t vecs [20];
  logic [4:0] op_list [17];

  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  function automatic res_t mk(input logic [7:0] o, input logic [7:0] h, input logic c,
                              input logic z, input logic e, input logic g, input logic l);
    res_t r;
    r = {o, h, c, z, e, g, l};
    return r;
  endfunction

  function automatic res_t sample();
    res_t r;
    r = {bus.out, bus.out_hi, bus.c_o, bus.zero, bus.equal, bus.gt, bus.lt};
    return r;
  endfunction

  // Reference model: plain integer arithmetic on the documented operation rules.
  function automatic res_t model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b, input logic ci);
    res_t r;
    int   ua, ub, sa, sb, n, t, t2, c;
    bit   cmp;
    r   = '0;
    cmp = 1'b0;
    ua  = int'(a);
    ub  = int'(b);
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    n   = int'(b[2:0]);
    c   = int'(ci);
    t   = 0;
    case (op)
      OP_ADD:  begin t = ua + ub + c; r.out = t[7:0]; r.c_o = (t > 255); end
      OP_SUB:  begin t = ua - ub - c; r.out = t[7:0]; r.c_o = (t < 0); end
      OP_DEC:  begin t = ua - 1; r.out = t[7:0]; end
      OP_AND:  r.out = a & b;
      OP_OR:   r.out = a | b;
      OP_XOR:  r.out = a ^ b;
      OP_NOT:  r.out = ~a;
      OP_SHL:  begin t = ua << n; r.out = t[7:0]; r.c_o = (n != 0) ? t[8] : 1'b0; end
      OP_SHR:  begin t = ua >> n; r.out = t[7:0]; t2 = ua >> (n - 1); r.c_o = (n != 0) ? t2[0] : 1'b0; end
      OP_ASR:  begin t = sa >>> n; r.out = t[7:0]; t2 = ua >> (n - 1); r.c_o = (n != 0) ? t2[0] : 1'b0; end
      OP_ROL:  begin t = (ua << n) | (ua >> (8 - n)); r.out = t[7:0]; r.c_o = (n != 0) ? t[0] : 1'b0; end
      OP_ROR:  begin t = (ua >> n) | (ua << (8 - n)); r.out = t[7:0]; r.c_o = (n != 0) ? t[7] : 1'b0; end
      OP_RCR:  begin t = (c << 7) | (ua >> 1); r.out = t[7:0]; r.c_o = a[0]; end
      OP_RCL:  begin t = (ua << 1) | c; r.out = t[7:0]; r.c_o = a[7]; end
      OP_CMP:  begin cmp = 1'b1; r.equal = (ua == ub); r.gt = (sa > sb); r.lt = (sa < sb); end
      OP_CMPU: begin cmp = 1'b1; r.equal = (ua == ub); r.gt = (ua > ub); r.lt = (ua < ub); end
      OP_MUL:  begin t = ua * ub; r.out = t[7:0]; r.hi = t[15:8]; r.c_o = (t > 255); end
      default: r.out = 8'h00;
    endcase
    r.zero = cmp ? r.equal : (r.out == 8'h00);
    return r;
  endfunction

  task automatic checkOutput(input string name, input res_t got, input res_t exp, input bit ok);
    checks++;
    if (!ok || got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got valid=%0b out=%h hi=%h c_o=%b zero=%b eq=%b gt=%b lt=%b, want valid=1 out=%h hi=%h c_o=%b zero=%b eq=%b gt=%b lt=%b",
               name, ok, got.out, got.hi, got.c_o, got.zero, got.equal, got.gt, got.lt,
               exp.out, exp.hi, exp.c_o, exp.zero, exp.equal, exp.gt, exp.lt);
    end
  endtask

  task automatic checkVal(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  // One full transaction; stall holds out_ready low for that many cycles after the result appears.
  task automatic applyStimulus(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic ci, input int stall, output res_t got, output bit ok);
    int cyc;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.c_i       = ci;
    bus.out_ready = (stall == 0);
    cyc = 0;
    while (!bus.in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = 8'($urandom);
    bus.in_b     = 8'($urandom);
    bus.c_i      = 1'($urandom);
    @(negedge clk);
    cyc = 0;
    while (!bus.out_valid && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (stall) @(negedge clk);
    ok  = (bus.out_valid === 1'b1);
    got = sample();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    res_t got;
    res_t exp;
    bit   ok;
    int   busy;
    bit   saw_ready;
    logic [4:0] rop;

    vecs[0]  = '{"add_carry",   OP_ADD,  8'hF0, 8'h20, 1'b1, mk(8'h11, 8'h00, 1, 0, 0, 0, 0)};
    vecs[1]  = '{"sub_zero",    OP_SUB,  8'h05, 8'h05, 1'b0, mk(8'h00, 8'h00, 0, 1, 0, 0, 0)};
    vecs[2]  = '{"sub_borrow",  OP_SUB,  8'h00, 8'h01, 1'b0, mk(8'hFF, 8'h00, 1, 0, 0, 0, 0)};
    vecs[3]  = '{"shr_3",       OP_SHR,  8'h81, 8'h03, 1'b0, mk(8'h10, 8'h00, 0, 0, 0, 0, 0)};
    vecs[4]  = '{"asr_7",       OP_ASR,  8'h80, 8'h07, 1'b0, mk(8'hFF, 8'h00, 0, 0, 0, 0, 0)};
    vecs[5]  = '{"rol_1",       OP_ROL,  8'h81, 8'h01, 1'b0, mk(8'h03, 8'h00, 1, 0, 0, 0, 0)};
    vecs[6]  = '{"cmp_signed",  OP_CMP,  8'hFF, 8'h01, 1'b0, mk(8'h00, 8'h00, 0, 0, 0, 0, 1)};
    vecs[7]  = '{"cmpu",        OP_CMPU, 8'hFF, 8'h01, 1'b0, mk(8'h00, 8'h00, 0, 0, 0, 1, 0)};
    vecs[8]  = '{"cmp_equal",   OP_CMP,  8'h7E, 8'h7E, 1'b0, mk(8'h00, 8'h00, 0, 1, 1, 0, 0)};
    vecs[9]  = '{"mul_ff",      OP_MUL,  8'hFF, 8'hFF, 1'b0, mk(8'h01, 8'hFE, 1, 0, 0, 0, 0)};
    vecs[10] = '{"undef_op",    5'h1F,   8'h12, 8'h34, 1'b1, mk(8'h00, 8'h00, 0, 1, 0, 0, 0)};
    vecs[11] = '{"dec_wrap",    OP_DEC,  8'h00, 8'h00, 1'b0, mk(8'hFF, 8'h00, 0, 0, 0, 0, 0)};
    vecs[12] = '{"rcr",         OP_RCR,  8'h01, 8'h00, 1'b1, mk(8'h80, 8'h00, 1, 0, 0, 0, 0)};
    vecs[13] = '{"rcl",         OP_RCL,  8'h80, 8'h00, 1'b0, mk(8'h00, 8'h00, 1, 1, 0, 0, 0)};
    vecs[14] = '{"shl_n0",      OP_SHL,  8'hA5, 8'h08, 1'b0, mk(8'hA5, 8'h00, 0, 0, 0, 0, 0)};
    vecs[15] = '{"ror_1",       OP_ROR,  8'h01, 8'h01, 1'b0, mk(8'h80, 8'h00, 1, 0, 0, 0, 0)};
    vecs[16] = '{"not",         OP_NOT,  8'h0F, 8'h00, 1'b0, mk(8'hF0, 8'h00, 0, 0, 0, 0, 0)};
    vecs[17] = '{"xor",         OP_XOR,  8'hF0, 8'hFF, 1'b0, mk(8'h0F, 8'h00, 0, 0, 0, 0, 0)};
    vecs[18] = '{"mul_zero",    OP_MUL,  8'h00, 8'h37, 1'b0, mk(8'h00, 8'h00, 0, 1, 0, 0, 0)};
    vecs[19] = '{"add_wrap",    OP_ADD,  8'hFF, 8'h00, 1'b1, mk(8'h00, 8'h00, 1, 1, 0, 0, 0)};

    op_list = '{OP_ADD, OP_SUB, OP_DEC, OP_XOR, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_RCR,
                OP_RCL, OP_ASR, OP_CMP, OP_CMPU, OP_NOT, OP_ROL, OP_ROR, OP_MUL};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.c_i       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("rst_in_ready", int'(bus.in_ready), 1);
    checkVal("rst_out_valid", int'(bus.out_valid), 0);
    checkOutput("rst_outputs", sample(), mk(8'h00, 8'h00, 0, 0, 0, 0, 0), 1'b1);

    // Back-to-back single-cycle ops
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op = OP_ADD; bus.in_a = 8'hF0; bus.in_b = 8'h20; bus.c_i = 1'b1;
    @(negedge clk);
    checkOutput("b2b_add", sample(), mk(8'h11, 8'h00, 1, 0, 0, 0, 0), bus.out_valid === 1'b1);
    checkVal("b2b_in_ready", int'(bus.in_ready), 1);
    bus.op = OP_SUB; bus.in_a = 8'h05; bus.in_b = 8'h05; bus.c_i = 1'b0;
    @(negedge clk);
    checkOutput("b2b_sub", sample(), mk(8'h00, 8'h00, 0, 1, 0, 0, 0), bus.out_valid === 1'b1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkVal("b2b_idle", int'(bus.out_valid), 0);

    // MUL latency and result hold under back-pressure
    bus.in_valid = 1'b1; bus.op = OP_MUL; bus.in_a = 8'hFF; bus.in_b = 8'hFF; bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0; bus.in_a = 8'h00; bus.in_b = 8'h00;
    busy = 0;
    saw_ready = 1'b0;
    @(negedge clk);
    while (!bus.out_valid && busy < 20) begin
      if (bus.in_ready) saw_ready = 1'b1;
      busy++;
      @(negedge clk);
    end
    checkVal("mul_busy_cycles", busy, 8);
    checkVal("mul_ready_low", int'(saw_ready), 0);
    exp = mk(8'h01, 8'hFE, 1, 0, 0, 0, 0);
    checkOutput("mul_ffxff", sample(), exp, bus.out_valid === 1'b1);
    bus.in_valid = 1'b1; bus.op = OP_ADD; bus.in_a = 8'h01; bus.in_b = 8'h01; bus.c_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("mul_hold%0d", i), sample(), exp, bus.out_valid === 1'b1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkVal("mul_consumed", int'(bus.out_valid), 0);

    // Reset in the middle of a MUL discards it
    applyStimulus(OP_ADD, 8'h01, 8'h01, 1'b0, 0, got, ok);
    checkOutput("pre_rst_add", got, mk(8'h02, 8'h00, 0, 0, 0, 0, 0), ok);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_MUL; bus.in_a = 8'hFF; bus.in_b = 8'hFF;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checkVal("rst_mul_valid", int'(bus.out_valid), 0);
    checkVal("rst_mul_ready", int'(bus.in_ready), 1);
    checkOutput("rst_mul_outputs", sample(), mk(8'h00, 8'h00, 0, 0, 0, 0, 0), 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = OP_ADD; bus.in_a = 8'h01; bus.in_b = 8'h01; bus.c_i = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("post_rst_add", sample(), mk(8'h02, 8'h00, 0, 0, 0, 0, 0), bus.out_valid === 1'b1);
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, i % 3, got, ok);
      checkOutput(vecs[i].name, got, vecs[i].exp, ok);
    end

    // Random operations against the reference model
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) rop = 5'($urandom);
      else rop = op_list[$urandom_range(0, 16)];
      bus.in_a = 8'($urandom);
      bus.in_b = 8'($urandom);
      bus.c_i  = 1'($urandom);
      exp = model(rop, bus.in_a, bus.in_b, bus.c_i);
      applyStimulus(rop, bus.in_a, bus.in_b, bus.c_i, $urandom_range(0, 2), got, ok);
      checkOutput($sformatf("rand%0d_op%02h", i, rop), got, exp, ok);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
